// File: rtl/batcharger_ctrl_if.sv
// ADC sample stream into the charge-mode controller and the mode/target outputs it drives.
// master = controller side, slave = analog front end / observer side.
interface batcharger_ctrl_if #(
  parameter int AW = 10,
  parameter int IW = 8
);
  logic          adc_valid;
  logic [AW-1:0] adc_vbat;
  logic [AW-1:0] adc_ibat;
  logic [AW-1:0] adc_vtemp;
  logic          tc;
  logic          cc;
  logic          cv;
  logic [IW-1:0] icode;
  logic [AW-1:0] vcode;
  logic          done;
  logic          hold;

  modport master (
    input  adc_valid, adc_vbat, adc_ibat, adc_vtemp,
    output tc, cc, cv, icode, vcode, done, hold
  );

  modport slave (
    output adc_valid, adc_vbat, adc_ibat, adc_vtemp,
    input  tc, cc, cv, icode, vcode, done, hold
  );
endinterface

// File: rtl/batcharger_ctrl.sv
// Charge-mode controller: walks IDLE/TC/CC/CV/END/HOLD from debounced ADC samples and
// drives registered mode flags plus current/voltage DAC targets.
module batcharger_ctrl #(
  parameter int AW      = 10,
  parameter int IW      = 8,
  parameter int IC_STEP = 8,
  parameter int DEB     = 4,
  parameter int TMAX    = 2**20
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          en,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] vtc_th,
  input  logic [AW-1:0] vcv_th,
  input  logic [AW-1:0] vrech_th,
  input  logic [AW-1:0] tmin_th,
  input  logic [AW-1:0] tmax_th,
  batcharger_ctrl_if.master bus
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_TC   = 3'd1;
  localparam logic [2:0] ST_CC   = 3'd2;
  localparam logic [2:0] ST_CV   = 3'd3;
  localparam logic [2:0] ST_END  = 3'd4;
  localparam logic [2:0] ST_HOLD = 3'd5;

  localparam int              DW       = $clog2(DEB + 1);
  localparam int              TW       = $clog2(TMAX + 1);
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB - 1);
  localparam logic [TW-1:0]   TMAX_C   = TW'(TMAX);
  localparam logic [31:0]     IMAX     = (32'd1 << IW) - 32'd1;

  logic [2:0]    state_r, state_nxt_s;
  logic [DW-1:0] deb_r, deb_nxt_s, deb_d_s;
  logic [TW-1:0] timer_r, timer_nxt_s, timer_d_s;
  logic [31:0]   icc_wide_s;
  logic [IW-1:0] icc_s, itc_s, icut_s;
  logic          temp_ok_s, active_s, qual_s;

  logic          tc_r, cc_r, cv_r, done_r, hold_r;
  logic [IW-1:0] icode_r;
  logic [AW-1:0] vcode_r;

  // Successor of each state once its own exit condition has been debounced.
  function automatic logic [2:0] exit_to(input logic [2:0] st);
    case (st)
      ST_TC:   exit_to = ST_CC;
      ST_CC:   exit_to = ST_CV;
      ST_CV:   exit_to = ST_END;
      ST_END:  exit_to = ST_TC;
      ST_HOLD: exit_to = ST_TC;
      default: exit_to = ST_IDLE;
    endcase
  endfunction

  // Current targets derived from the capacity select, saturating the CC code.
  always_comb begin
    icc_wide_s = (32'(sel) + 32'd1) * 32'(IC_STEP);
    if (icc_wide_s > IMAX) begin
      icc_s = '1;
    end else begin
      icc_s = icc_wide_s[IW-1:0];
    end
    itc_s  = icc_s >> 3'd3;
    icut_s = icc_s >> 3'd4;
  end

  // Exit condition of the current state for the sample on the bus.
  always_comb begin
    temp_ok_s = (bus.adc_vtemp >= tmin_th) && (bus.adc_vtemp <= tmax_th);
    active_s  = (state_r == ST_TC) || (state_r == ST_CC) || (state_r == ST_CV);
    case (state_r)
      ST_TC:   qual_s = bus.adc_vbat >= vtc_th;
      ST_CC:   qual_s = bus.adc_vbat >= vcv_th;
      ST_CV:   qual_s = 32'(bus.adc_ibat) < 32'(icut_s);
      ST_END:  qual_s = bus.adc_vbat < vrech_th;
      ST_HOLD: qual_s = temp_ok_s;
      default: qual_s = 1'b0;
    endcase
  end

  // Next state; temperature beats the CV timeout, which beats the debounced exits.
  always_comb begin
    state_nxt_s = state_r;
    deb_nxt_s   = deb_r;
    if ((state_r == ST_CV) && (timer_r != TMAX_C)) begin
      timer_nxt_s = timer_r + TW'(1);
    end else begin
      timer_nxt_s = timer_r;
    end
    if (!en) begin
      state_nxt_s = ST_IDLE;
      deb_nxt_s   = '0;
      timer_nxt_s = '0;
    end else if (state_r == ST_IDLE) begin
      state_nxt_s = ST_TC;
    end else if (bus.adc_valid && active_s && !temp_ok_s) begin
      state_nxt_s = ST_HOLD;
    end else if ((state_r == ST_CV) && (timer_nxt_s == TMAX_C)) begin
      state_nxt_s = ST_END;
    end else if (bus.adc_valid && qual_s) begin
      if (deb_r >= DEB_LAST) begin
        state_nxt_s = exit_to(state_r);
      end else begin
        deb_nxt_s = deb_r + DW'(1);
      end
    end else if (bus.adc_valid) begin
      deb_nxt_s = '0;
    end else begin
      deb_nxt_s = deb_r;
    end
  end

  // Every state change restarts both the debounce count and the CV timer.
  assign deb_d_s   = (state_nxt_s != state_r) ? '0 : deb_nxt_s;
  assign timer_d_s = (state_nxt_s != state_r) ? '0 : timer_nxt_s;

  // State, debounce and timer registers.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_r <= ST_IDLE;
      deb_r   <= '0;
      timer_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      deb_r   <= deb_d_s;
      timer_r <= timer_d_s;
    end
  end

  // Registered outputs follow the state register by one clock.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tc_r    <= 1'b0;
      cc_r    <= 1'b0;
      cv_r    <= 1'b0;
      done_r  <= 1'b0;
      hold_r  <= 1'b0;
      icode_r <= '0;
      vcode_r <= '0;
    end else begin
      tc_r   <= (state_r == ST_TC);
      cc_r   <= (state_r == ST_CC);
      cv_r   <= (state_r == ST_CV);
      done_r <= (state_r == ST_END);
      hold_r <= (state_r == ST_HOLD);
      case (state_r)
        ST_TC:   icode_r <= itc_s;
        ST_CC:   icode_r <= icc_s;
        ST_CV:   icode_r <= icc_s;
        default: icode_r <= '0;
      endcase
      vcode_r <= (state_r == ST_CV) ? vcv_th : '0;
    end
  end

  assign bus.tc    = tc_r;
  assign bus.cc    = cc_r;
  assign bus.cv    = cv_r;
  assign bus.done  = done_r;
  assign bus.hold  = hold_r;
  assign bus.icode = icode_r;
  assign bus.vcode = vcode_r;
endmodule

// File: tb/tb_batcharger_ctrl.sv
// Bench for batcharger_ctrl: directed scenarios plus randomized traffic against a mode-level model.
module tb_batcharger_ctrl;
  localparam int AW = 10, IW = 8, IC_STEP = 8, DEB = 4, TMAX = 64;
  localparam int M_IDLE = 0, M_TC = 1, M_CC = 2, M_CV = 3, M_END = 4, M_HOLD = 5;

  logic          clk = 1'b0;
  logic          rstz = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    sel = 4'd8;
  logic [AW-1:0] vtc_th = 10'd300, vcv_th = 10'd600, vrech_th = 10'd550;
  logic [AW-1:0] tmin_th = 10'd200, tmax_th = 10'd800;

  batcharger_ctrl_if #(.AW(AW), .IW(IW)) bus ();

  batcharger_ctrl #(.AW(AW), .IW(IW), .IC_STEP(IC_STEP), .DEB(DEB), .TMAX(TMAX)) dut (
    .clk(clk), .rstz(rstz), .en(en), .sel(sel),
    .vtc_th(vtc_th), .vcv_th(vcv_th), .vrech_th(vrech_th),
    .tmin_th(tmin_th), .tmax_th(tmax_th), .bus(bus)
  );

  always #5 clk = ~clk;

  // {tc, cc, cv, done, hold, icode, vcode}
  wire [22:0] obs = {bus.tc, bus.cc, bus.cv, bus.done, bus.hold, bus.icode, bus.vcode};

  int vectors = 0, miscompares = 0;
  int m_mode = M_IDLE, m_cnt = 0, m_cyc = 0, m_cv_start = 0;
  logic [22:0] m_out = 23'd0;

  function automatic int icc_of(input logic [3:0] s);
    int v;
    v = (int'(s) + 1) * IC_STEP;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [22:0] model_out(input int mode);
    int icc;
    icc = icc_of(sel);
    case (mode)
      M_TC:    return {5'b10000, 8'(icc / 8), 10'd0};
      M_CC:    return {5'b01000, 8'(icc), 10'd0};
      M_CV:    return {5'b00100, 8'(icc), vcv_th};
      M_END:   return {5'b00010, 18'd0};
      M_HOLD:  return {5'b00001, 18'd0};
      default: return 23'd0;
    endcase
  endfunction

  // Mode-level reference: one call per rising clock edge with the inputs present at that edge.
  task automatic model_step();
    int nm;
    bit hot, q;
    m_out = model_out(m_mode);
    m_cyc++;
    nm = m_mode;
    hot = (bus.adc_vtemp < tmin_th) || (bus.adc_vtemp > tmax_th);
    if (!en) begin
      nm = M_IDLE;
      m_cnt = 0;
    end else if (m_mode == M_IDLE) begin
      nm = M_TC;
    end else if (bus.adc_valid && hot && (m_mode == M_TC || m_mode == M_CC || m_mode == M_CV)) begin
      nm = M_HOLD;
    end else if (m_mode == M_CV && (m_cyc - m_cv_start) >= TMAX) begin
      nm = M_END;
    end else if (bus.adc_valid) begin
      case (m_mode)
        M_TC:    q = bus.adc_vbat >= vtc_th;
        M_CC:    q = bus.adc_vbat >= vcv_th;
        M_CV:    q = int'(bus.adc_ibat) < icc_of(sel) / 16;
        M_END:   q = bus.adc_vbat < vrech_th;
        default: q = !hot;
      endcase
      m_cnt = q ? m_cnt + 1 : 0;
      if (m_cnt >= DEB) begin
        case (m_mode)
          M_TC:    nm = M_CC;
          M_CC:    nm = M_CV;
          M_CV:    nm = M_END;
          default: nm = M_TC;
        endcase
      end
    end
    if (nm != m_mode) begin
      m_cnt = 0;
      if (nm == M_CV) m_cv_start = m_cyc;
    end
    m_mode = nm;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rstz) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_out  = 23'd0;
      m_cyc++;
    end else begin
      model_step();
    end
    #1;
  endtask

  // One valid sample followed by one idle cycle, so outputs reflect the post-sample state on return.
  task automatic sample(input logic [9:0] vb, input logic [9:0] ib, input logic [9:0] vt);
    bus.adc_vbat  = vb;
    bus.adc_ibat  = ib;
    bus.adc_vtemp = vt;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    tick();
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstz = 1'b0;
    repeat (3) tick();
    vectors++;
    if (obs !== 23'd0) begin
      $display("FAIL reset_outputs: got %h expected %h", obs, 23'd0);
      miscompares++;
    end
    rstz = 1'b1;
    en = 1'b1;
    tick();
    tick();
    vectors++;
    if (obs !== {5'b10000, 8'd9, 10'd0}) begin
      $display("FAIL reset_release_tc: got %h expected %h", obs, {5'b10000, 8'd9, 10'd0});
      miscompares++;
    end
    repeat (4) sample(10'd400, 10'd50, 10'd500);
    vectors++;
    if (obs !== {5'b01000, 8'd72, 10'd0}) begin
      $display("FAIL reset_reach_cc: got %h expected %h", obs, {5'b01000, 8'd72, 10'd0});
      miscompares++;
    end
    rstz = 1'b0;
    #1;
    vectors++;
    if (obs !== 23'd0) begin
      $display("FAIL reset_async_mid_cc: got %h expected %h", obs, 23'd0);
      miscompares++;
    end
    tick();
    tick();
    rstz = 1'b1;
    tick();
    tick();
    vectors++;
    if (obs !== {5'b10000, 8'd9, 10'd0}) begin
      $display("FAIL reset_rerelease_tc: got %h expected %h", obs, {5'b10000, 8'd9, 10'd0});
      miscompares++;
    end
  endtask

  task automatic test_codes();
    restart();
    repeat (4) sample(10'd400, 10'd50, 10'd500);
    vectors++;
    if (obs !== {5'b01000, 8'd72, 10'd0}) begin
      $display("FAIL codes_cc: got %h expected %h", obs, {5'b01000, 8'd72, 10'd0});
      miscompares++;
    end
    repeat (4) sample(10'd650, 10'd50, 10'd500);
    vectors++;
    if (obs !== {5'b00100, 8'd72, 10'd600}) begin
      $display("FAIL codes_cv: got %h expected %h", obs, {5'b00100, 8'd72, 10'd600});
      miscompares++;
    end
  endtask

  task automatic test_debounce();
    restart();
    repeat (2) sample(10'd400, 10'd50, 10'd500);
    sample(10'd299, 10'd50, 10'd500);
    repeat (3) sample(10'd300, 10'd50, 10'd500);
    vectors++;
    if (obs !== {5'b10000, 8'd9, 10'd0}) begin
      $display("FAIL deb_dip_restarts: got %h expected %h", obs, {5'b10000, 8'd9, 10'd0});
      miscompares++;
    end
    sample(10'd300, 10'd50, 10'd500);
    vectors++;
    if (obs !== {5'b01000, 8'd72, 10'd0}) begin
      $display("FAIL deb_fourth_sample: got %h expected %h", obs, {5'b01000, 8'd72, 10'd0});
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    int n;
    repeat (4) sample(10'd650, 10'd4, 10'd500);
    vectors++;
    if (obs !== {5'b00100, 8'd72, 10'd600}) begin
      $display("FAIL timeout_cv_entry: got %h expected %h", obs, {5'b00100, 8'd72, 10'd600});
      miscompares++;
    end
    n = 0;
    bus.adc_valid = 1'b1;
    while (bus.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    bus.adc_valid = 1'b0;
    vectors++;
    if (n !== TMAX) begin
      $display("FAIL timeout_cycles: got %0d expected %0d", n, TMAX);
      miscompares++;
    end
    vectors++;
    if (obs !== {5'b00010, 18'd0}) begin
      $display("FAIL timeout_end: got %h expected %h", obs, {5'b00010, 18'd0});
      miscompares++;
    end
  endtask

  task automatic test_recharge();
    repeat (2) sample(10'd549, 10'd0, 10'd500);
    sample(10'd550, 10'd0, 10'd500);
    repeat (3) sample(10'd549, 10'd0, 10'd500);
    vectors++;
    if (obs !== {5'b00010, 18'd0}) begin
      $display("FAIL rech_boundary_breaks: got %h expected %h", obs, {5'b00010, 18'd0});
      miscompares++;
    end
    sample(10'd549, 10'd0, 10'd500);
    vectors++;
    if (obs !== {5'b10000, 8'd9, 10'd0}) begin
      $display("FAIL rech_to_tc: got %h expected %h", obs, {5'b10000, 8'd9, 10'd0});
      miscompares++;
    end
    en = 1'b0;
    bus.adc_vbat = 10'd400;
    bus.adc_valid = 1'b1;
    tick();
    bus.adc_valid = 1'b0;
    vectors++;
    if (obs !== {5'b10000, 8'd9, 10'd0}) begin
      $display("FAIL en_fall_registered: got %h expected %h", obs, {5'b10000, 8'd9, 10'd0});
      miscompares++;
    end
    tick();
    vectors++;
    if (obs !== 23'd0) begin
      $display("FAIL en_fall_idle: got %h expected %h", obs, 23'd0);
      miscompares++;
    end
  endtask

  task automatic test_temp();
    restart();
    repeat (4) sample(10'd400, 10'd50, 10'd500);
    sample(10'd400, 10'd50, 10'd801);
    vectors++;
    if (obs !== {5'b00001, 18'd0}) begin
      $display("FAIL temp_hold: got %h expected %h", obs, {5'b00001, 18'd0});
      miscompares++;
    end
    sample(10'd400, 10'd50, 10'd800);
    sample(10'd400, 10'd50, 10'd200);
    sample(10'd400, 10'd50, 10'd800);
    vectors++;
    if (obs !== {5'b00001, 18'd0}) begin
      $display("FAIL temp_hold_three: got %h expected %h", obs, {5'b00001, 18'd0});
      miscompares++;
    end
    sample(10'd400, 10'd50, 10'd500);
    vectors++;
    if (obs !== {5'b10000, 8'd9, 10'd0}) begin
      $display("FAIL temp_restart_tc: got %h expected %h", obs, {5'b10000, 8'd9, 10'd0});
      miscompares++;
    end
  endtask

  task automatic test_random();
    int base, ilvl;
    base = 320;
    ilvl = 6;
    for (int i = 0; i < 3000; i++) begin
      if (en && $urandom_range(0, 299) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      if ($urandom_range(0, 499) == 0) sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       base = int'(vtc_th);
          1:       base = int'(vcv_th);
          default: base = int'(vrech_th);
        endcase
        base = base + $urandom_range(0, 40) - 20;
      end
      if ($urandom_range(0, 39) == 0) ilvl = $urandom_range(0, 10);
      bus.adc_valid = 1'($urandom_range(0, 1));
      bus.adc_vbat  = 10'(base);
      bus.adc_ibat  = 10'(ilvl);
      bus.adc_vtemp = ($urandom_range(0, 99) < 97) ? 10'd500 : 10'($urandom_range(0, 1023));
      tick();
      vectors++;
      if (obs !== m_out) begin
        $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, m_out);
        miscompares++;
      end
    end
    bus.adc_valid = 1'b0;
  endtask

  initial begin
    bus.adc_valid = 1'b0;
    bus.adc_vbat  = 10'd0;
    bus.adc_ibat  = 10'd0;
    bus.adc_vtemp = 10'd500;
    test_reset();
    test_codes();
    test_debounce();
    test_timeout();
    test_recharge();
    test_temp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
